stopwatch_display: RTL and testbench

- Reader/display end of the stopwatch time counter.
- Samples the 15-bit binary elapsed-time count (tenths of a second, 0..9999) produced by the delay counter.
- Converts the count to four BCD digits with a sequential shift-add-3 (double-dabble) engine.
- Drives a time-multiplexed 4-digit active-low 7-segment display with a decimal point and leading-zero blanking.

---
 rtl/stopwatch_display.sv | 192 +++++++++++++++++++
 tb/tb_stopwatch_display.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_display.sv
// Stopwatch reader/display: samples the tenths-of-a-second count, converts it
// to four BCD digits with a sequential double-dabble engine, and scans a
// 4-digit active-low 7-segment display with decimal point and leading-zero
// blanking.
module stopwatch_display #(
  parameter int SCAN_DIV = 50000,
  parameter int DP_POS   = 1,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [14:0] counter,
  input  logic        hold,
  output logic [15:0] bcd,
  output logic        busy,
  output logic        done,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an
);

  localparam int         DIV_W    = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [1:0] DP_IDX   = 2'(DP_POS);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_COMMIT} state_t;

  state_t             r_state;
  state_t             w_next;
  logic [14:0]        r_last;
  logic [14:0]        r_shreg;
  logic [15:0]        r_scratch;
  logic [3:0]         r_iter;
  logic [15:0]        r_bcd;
  logic               r_busy;
  logic               r_done;
  logic [DIV_W-1:0]   r_div;
  logic [1:0]         r_idx;

  logic [14:0]        w_clamped;
  logic               w_sample;
  logic               w_load;
  logic               w_shift;
  logic               w_commit;
  logic [15:0]        w_adj;
  logic [30:0]        w_cat;
  logic [3:0]         w_digit;
  logic [3:0]         w_lz;
  logic               w_blank;

  // Counts above the display range pin to 9999.
  function automatic logic [14:0] clamp9999(input logic [14:0] v);
    return (v > 15'd9999) ? 15'd9999 : v;
  endfunction

  // Double-dabble correction: every nibble >= 5 gets +3 before the shift.
  function automatic logic [15:0] add3(input logic [15:0] s);
    logic [15:0] r;
    r = s;
    for (int i = 0; i < 4; i++) begin
      if (s[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = s[i*4 +: 4] + 4'd3;
    end
    return r;
  endfunction

  // Active-low {g,f,e,d,c,b,a}; non-decimal nibbles show blank.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return 7'h7F;
    endcase
  endfunction

  assign w_clamped = clamp9999(counter);
  assign w_sample  = !hold && (w_clamped != r_last);
  assign w_adj     = add3(r_scratch);
  assign w_cat     = {w_adj, r_shreg};

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // FSM next state: sample in IDLE, 15 shift iterations, one commit cycle.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_sample) w_next = S_SHIFT;
      S_SHIFT:  if (r_iter == 4'd14) w_next = S_COMMIT;
      S_COMMIT: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // FSM outputs: datapath strobes for load, shift and commit.
  always_comb begin
    w_load   = 1'b0;
    w_shift  = 1'b0;
    w_commit = 1'b0;
    case (r_state)
      S_IDLE:   w_load   = w_sample;
      S_SHIFT:  w_shift  = 1'b1;
      S_COMMIT: w_commit = 1'b1;
      default:  ;
    endcase
  end

  // Control and result registers: last sample, iteration count, bcd, flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last <= '0;
      r_iter <= '0;
      r_bcd  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_load) begin
        r_last <= w_clamped;
        r_iter <= '0;
        r_busy <= 1'b1;
      end
      if (w_shift) r_iter <= r_iter + 4'd1;
      if (w_commit) begin
        r_bcd  <= r_scratch;
        r_done <= 1'b1;
        r_busy <= 1'b0;
      end
    end
  end

  // Conversion datapath: load binary value, then adjust-and-shift MSB first.
  always_ff @(posedge clk) begin
    if (w_load) begin
      r_shreg   <= w_clamped;
      r_scratch <= '0;
    end else if (w_shift) begin
      {r_scratch, r_shreg} <= {w_cat[29:0], 1'b0};
    end
  end

  // Digit scan: divider sets the slot length, index cycles 0..3.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div <= '0;
      r_idx <= '0;
    end else if (r_div == DIV_LAST) begin
      r_div <= '0;
      r_idx <= r_idx + 2'd1;
    end else begin
      r_div <= r_div + 1'b1;
    end
  end

  // A digit is a leading zero when it and every digit above it are zero.
  assign w_lz[3] = (r_bcd[15:12] == 4'd0);
  assign w_lz[2] = w_lz[3] && (r_bcd[11:8] == 4'd0);
  assign w_lz[1] = w_lz[2] && (r_bcd[7:4] == 4'd0);
  assign w_lz[0] = w_lz[1] && (r_bcd[3:0] == 4'd0);

  // Select the nibble for the active digit slot.
  always_comb begin
    w_digit = r_bcd[3:0];
    case (r_idx)
      2'd0: w_digit = r_bcd[3:0];
      2'd1: w_digit = r_bcd[7:4];
      2'd2: w_digit = r_bcd[11:8];
      2'd3: w_digit = r_bcd[15:12];
      default: ;
    endcase
  end

  assign w_blank = BLANK_LZ && (r_idx > DP_IDX) && w_lz[r_idx];

  assign bcd  = r_bcd;
  assign busy = r_busy;
  assign done = r_done;
  assign seg  = w_blank ? 7'h7F : seg7(w_digit);
  assign dp   = (r_idx == DP_IDX) ? 1'b0 : 1'b1;
  assign an   = ~(4'b0001 << r_idx);

endmodule

// File: tb/tb_stopwatch_display.sv
// Testbench for stopwatch_display: directed conversions checked by a
// done-driven scoreboard, plus reset, hold, back-to-back and scan checks.
module tb_stopwatch_display;

  localparam int SCAN_DIV = 4;

  logic        clk;
  logic        rst;
  logic [14:0] counter;
  logic        hold;
  logic [15:0] bcd;
  logic        busy;
  logic        done;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic [15:0] bcd;
    int          due;
  } exp_t;

  exp_t q[$];

  stopwatch_display #(.SCAN_DIV(SCAN_DIV), .DP_POS(1), .BLANK_LZ(1'b1)) dut (
    .clk(clk), .rst(rst), .counter(counter), .hold(hold),
    .bcd(bcd), .busy(busy), .done(done), .seg(seg), .dp(dp), .an(an)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done pulse pops one expected result.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (done) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done=1 bcd=%0h expected no done (cycle %0d)", bcd, cyc);
        end else begin
          e = q.pop_front();
          chk("bcd", 32'(bcd), 32'(e.bcd));
          chk("latency", cyc, e.due);
          chk("busy_at_done", 32'(busy), 32'd0);
        end
      end else if (q.size() > 0 && cyc > q[0].due) begin
        e = q.pop_front();
        checks++;
        errors++;
        $display("FAIL done_timeout: got no done by cycle %0d expected bcd %0h at cycle %0d", cyc, e.bcd, e.due);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called just after a negedge: the next edge samples, result visible 17 edges on.
  task automatic start(input logic [14:0] v, input logic [15:0] exp);
    exp_t e;
    counter = v;
    e.bcd = exp;
    e.due = cyc + 17;
    q.push_back(e);
  endtask

  task automatic wait_q();
    int n = 0;
    while (q.size() != 0 && n < 80) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL wait_q: got %0d pending results expected 0", q.size());
      q.delete();
    end
    tick(2);
  endtask

  // Align to the index 3->0 wrap, then check 16 cycles of scanning.
  task automatic scan_check(input logic [6:0] s0, input logic [6:0] s1,
                            input logic [6:0] s2, input logic [6:0] s3);
    logic [6:0] s[4];
    logic [3:0] prev;
    int n = 0;
    int idx;
    s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
    prev = an;
    @(negedge clk);
    while (!(an == 4'b1110 && prev == 4'b0111) && n < 40) begin
      prev = an;
      @(negedge clk);
      n++;
    end
    chk("scan_wrap_found", 32'(n < 40), 32'd1);
    for (int k = 0; k < 16; k++) begin
      idx = k / 4;
      chk("an", 32'(an), 32'(~(4'b0001 << idx) & 4'hF));
      chk("seg", 32'(seg), 32'(s[idx]));
      chk("dp", 32'(dp), (idx == 1) ? 32'd0 : 32'd1);
      @(negedge clk);
    end
  endtask

  initial begin
    rst = 1'b1;
    counter = '0;
    hold = 1'b0;
    tick(3);
    // Reset state.
    chk("rst_bcd", 32'(bcd), 32'h0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_an", 32'(an), 32'b1110);
    chk("rst_seg", 32'(seg), 32'b1000000);
    chk("rst_dp", 32'(dp), 32'd1);
    rst = 1'b0;
    // Counter equals last: no conversion.
    tick(5);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_bcd", 32'(bcd), 32'h0);

    // Plain conversion; busy rises on the sample edge.
    start(15'd1234, 16'h1234);
    tick(1);
    chk("busy_rise", 32'(busy), 32'd1);
    wait_q();
    scan_check(7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001);

    // Clamp, then leading-zero blanking.
    start(15'd12000, 16'h9999);
    wait_q();
    start(15'd5, 16'h0005);
    wait_q();
    scan_check(7'b0010010, 7'b1000000, 7'h7F, 7'h7F);
    // Zero below a nonzero digit stays visible.
    start(15'd1005, 16'h1005);
    wait_q();
    scan_check(7'b0010010, 7'b1000000, 7'b1000000, 7'b1111001);

    // Hold freezes sampling.
    start(15'd42, 16'h0042);
    wait_q();
    hold = 1'b1;
    counter = 15'd77;
    tick(25);
    chk("hold_bcd", 32'(bcd), 32'h0042);
    chk("hold_busy", 32'(busy), 32'd0);
    hold = 1'b0;
    start(15'd77, 16'h0077);
    wait_q();

    // Counter change mid-conversion is picked up after commit.
    begin
      exp_t e;
      int c0;
      c0 = cyc;
      start(15'd100, 16'h0100);
      tick(5);
      counter = 15'd101;
      e.bcd = 16'h0101;
      e.due = c0 + 34;
      q.push_back(e);
    end
    wait_q();

    // Reset in the middle of converting 9999.
    counter = 15'd9999;
    tick(8);
    rst = 1'b1;
    #1;
    chk("midrst_bcd", 32'(bcd), 32'h0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    tick(1);
    rst = 1'b0;
    start(15'd9999, 16'h9999);
    wait_q();
    scan_check(7'b0010000, 7'b0010000, 7'b0010000, 7'b0010000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish expected finish by 1000000 ns");
    $fatal(1, "watchdog expired");
  end

endmodule
